// File: rtl/sr_cmd_driver.sv
// Command driver for one SR flip-flop: turns set/clear/toggle requests into
// mutually exclusive, width-programmable S/R pulses and checks Q afterwards.
module sr_cmd_driver #(
  parameter int PULSE_W = 1,
  parameter int GAP_W   = 1,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [CNT_W-1:0] req_len,
  output logic             S,
  output logic             R,
  input  logic             q_fb,
  output logic             q_shadow,
  output logic             busy,
  output logic             err_mismatch,
  input  logic             err_clr,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic       HAS_GAP  = (GAP_W > 0);
  localparam logic [CNT_W-1:0] PULSE_CNT = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] GAP_CNT   = CNT_W'(GAP_W);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tgt_q, tgt_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             shadow_q, shadow_d;
  logic             chk_q, chk_d;
  logic             err_q, err_d;
  logic             accept;
  logic             tgt_new;

  // Handshake: a request transfers on any rising edge where req_valid and
  // req_ready are both high; req_op/req_len are sampled only at that edge.
  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tgt_q    <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      shadow_q <= 1'b0;
      chk_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      s_q      <= s_d;
      r_q      <= r_d;
      shadow_q <= shadow_d;
      chk_q    <= chk_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    s_d      = s_q;
    r_d      = r_q;
    shadow_d = shadow_q;
    chk_d    = 1'b0;
    tgt_new  = ~shadow_q;

    case (req_op)
      OP_CLEAR: tgt_new = 1'b0;
      OP_SET:   tgt_new = 1'b1;
      default:  tgt_new = ~shadow_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        // Redundant set/clear and nop are consumed without a pulse.
        if (accept && (req_op != OP_NOP) && (tgt_new != shadow_q)) begin
          state_d = ST_PULSE;
          tgt_d   = tgt_new;
          cnt_d   = (req_len != '0) ? req_len : PULSE_CNT;
          s_d     = tgt_new;
          r_d     = ~tgt_new;
        end
      end
      ST_PULSE: begin
        if (cnt_q <= CNT_W'(1)) begin
          shadow_d = tgt_q;
          s_d      = 1'b0;
          r_d      = 1'b0;
          chk_d    = 1'b1;
          if (HAS_GAP) begin
            state_d = ST_GAP;
            cnt_d   = GAP_CNT;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        s_d     = 1'b0;
        r_d     = 1'b0;
      end
    endcase

    // A new mismatch wins over a simultaneous clear.
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (chk_q && (q_fb != shadow_q)) err_d = 1'b1;
  end

  always_comb begin
    req_ready    = (state_q == ST_IDLE) && !rst;
    busy         = (state_q != ST_IDLE);
    S            = s_q;
    R            = r_q;
    q_shadow     = shadow_q;
    err_mismatch = err_q;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Randomized bench for sr_cmd_driver with a flip-flop model on q_fb and a
// request-level reference model predicting every S/R pulse and the shadow state.
module tb_sr_cmd_driver;

  localparam int PULSE_W = 1;
  localparam int GAP_W   = 1;
  localparam int CNT_W   = 4;
  localparam int PW      = CNT_W + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [CNT_W-1:0] req_len;
  logic             S, R;
  logic             q_fb;
  logic             q_shadow;
  logic             busy;
  logic             err_mismatch;
  logic             err_clr;
  logic [1:0]       dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int last_acc = 0;

  logic          ff_q;
  logic          tie_low = 1'b0;
  logic          m_shadow = 1'b0;
  logic [PW-1:0] exp_q[$];
  int            run_len = 0;
  logic          run_kind = 1'b0;

  sr_cmd_driver #(.PULSE_W(PULSE_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_len(req_len), .S(S), .R(R), .q_fb(q_fb),
    .q_shadow(q_shadow), .busy(busy), .err_mismatch(err_mismatch),
    .err_clr(err_clr), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // flip-flop model driving the feedback
  always @(posedge clk) begin
    if (rst) ff_q <= 1'b0;
    else if (S) ff_q <= 1'b1;
    else if (R) ff_q <= 1'b0;
  end
  assign q_fb = tie_low ? 1'b0 : ff_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every finished S/R run is compared with the oldest predicted pulse
  always @(negedge clk) begin
    check("s_and_r", {31'd0, S & R}, 32'd0);
    if (rst) begin
      run_len = 0;
    end else if (S | R) begin
      run_kind = S;
      run_len++;
    end else if (run_len > 0) begin
      if (exp_q.size() == 0) check("pulse_unexpected", 32'd1, 32'd0);
      else check("pulse", {27'd0, run_kind, run_len[CNT_W-1:0]}, {27'd0, exp_q.pop_front()});
      run_len = 0;
    end
  end

  // reference model: resolve target, predict pulse, update expected FF state
  task automatic model_accept(input logic [1:0] op, input logic [CNT_W-1:0] len);
    logic tgt;
    logic [CNT_W-1:0] eff;
    if (op == 2'b00) return;
    tgt = (op == 2'b10) ? 1'b1 : (op == 2'b01) ? 1'b0 : ~m_shadow;
    if (tgt == m_shadow) return;
    eff = (len != 0) ? len : CNT_W'(PULSE_W);
    exp_q.push_back({tgt, eff});
    m_shadow = tgt;
  endtask

  // driver: present a request and hold it until the transfer edge
  task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] len);
    int t = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_len   = len;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("accept_timeout", 32'd1, 32'd0);
    last_acc = cyc;
    @(posedge clk);
    model_accept(op, len);
    #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_len   = CNT_W'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int a0;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_len = '0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_S", {31'd0, S}, 32'd0);
    check("rst_R", {31'd0, R}, 32'd0);
    check("rst_shadow", {31'd0, q_shadow}, 32'd0);
    check("rst_err", {31'd0, err_mismatch}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // single default-width set: S one cycle, ready low two cycles
    send(2'b10, 4'd0);
    @(negedge clk);
    check("t1_S_on", {31'd0, S}, 32'd1);
    check("t1_ready0", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("t1_S_off", {31'd0, S}, 32'd0);
    check("t1_ready1", {31'd0, req_ready}, 32'd0);
    check("t1_shadow", {31'd0, q_shadow}, 32'd1);
    @(negedge clk);
    check("t1_ready_back", {31'd0, req_ready}, 32'd1);
    check("t1_err", {31'd0, err_mismatch}, 32'd0);

    // redundant set and nop are each consumed in one cycle
    send(2'b10, 4'd2);
    a0 = last_acc;
    send(2'b00, 4'd5);
    check("t3_spacing", last_acc - a0, 32'd1);
    @(negedge clk);
    check("t3_busy", {31'd0, busy}, 32'd0);

    // clear, then set len 3 then clear
    send(2'b01, 4'd0);
    wait_idle();
    check("t2_shadow0", {31'd0, q_shadow}, 32'd0);
    send(2'b10, 4'd3);
    send(2'b01, 4'd0);
    wait_idle();
    check("t2_shadow_end", {31'd0, q_shadow}, 32'd0);

    // back-to-back toggles with valid held
    send(2'b11, 4'd0);
    a0 = last_acc;
    send(2'b11, 4'd0);
    check("t4_spacing", last_acc - a0, 32'(1 + PULSE_W + GAP_W));
    wait_idle();
    check("t4_shadow", {31'd0, q_shadow}, 32'd0);

    // feedback stuck low: mismatch flag is sticky until err_clr
    tie_low = 1'b1;
    send(2'b10, 4'd2);
    wait_idle();
    check("t5_err_set", {31'd0, err_mismatch}, 32'd1);
    tie_low = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_err_sticky", {31'd0, err_mismatch}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t5_err_clr", {31'd0, err_mismatch}, 32'd0);

    // reset in the second cycle of a 4-cycle S pulse
    send(2'b01, 4'd0);
    wait_idle();
    send(2'b10, 4'd4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    m_shadow = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t6_S", {31'd0, S}, 32'd0);
    check("t6_shadow", {31'd0, q_shadow}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_ready_in_rst", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("t6_ready", {31'd0, req_ready}, 32'd1);

    // random stream
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(2'($urandom_range(0, 3)), CNT_W'($urandom_range(0, 5)));
      if ($urandom_range(0, 2) == 0) begin
        wait_idle();
        check("rnd_shadow", {31'd0, q_shadow}, {31'd0, m_shadow});
      end
    end
    wait_idle();
    @(negedge clk);
    check("end_shadow", {31'd0, q_shadow}, {31'd0, m_shadow});
    check("end_exp_empty", exp_q.size(), 32'd0);
    check("end_err", {31'd0, err_mismatch}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sr_cmd_driver.md
Name: sr_cmd_driver

Overview:
Command-side driver for the team's SR flip-flop. It accepts set/clear/toggle requests over a valid/ready handshake and turns them into registered, mutually exclusive S/R pulses of programmable width, with an enforced idle gap between pulses. It keeps a shadow copy of the flip-flop state, skips redundant commands, and checks the flip-flop's Q feedback after every pulse. It sits between control logic and one srflipflop instance and guarantees the flip-flop never sees S=R=1.

Parameters:
PULSE_W, 1, default S/R pulse length in cycles; legal range 1..2^CNT_W-1
GAP_W, 1, forced S=R=0 cycles after each pulse; legal range 0..2^CNT_W-1
CNT_W, 4, width of req_len and the internal counters

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  driver can accept a request this cycle
req_op  in  2  00 nop, 01 clear, 10 set, 11 toggle
req_len  in  CNT_W  pulse length override; 0 selects PULSE_W
S  out  1  set drive to the flip-flop (registered)
R  out  1  reset drive to the flip-flop (registered)
q_fb  in  1  Q from the driven flip-flop
q_shadow  out  1  expected flip-flop state
busy  out  1  high in PULSE or GAP
err_mismatch  out  1  sticky flag: q_fb differed from q_shadow at the check point
err_clr  in  1  clears err_mismatch

Behaviour:
- Reset: when rst is high at an edge, the next cycle has state=IDLE, S=0, R=0, q_shadow=0, err_mismatch=0, and counters=0. The q_shadow value matches the flip-flop reset value.
- Reset mid-operation aborts the pulse or gap immediately. S and R are 0 from the next cycle, and no shadow update occurs.
- req_ready = (state==IDLE) && !rst. A transfer happens on a cycle where req_valid && req_ready.
- States and transitions:
  - IDLE: on a transfer, resolve the target. Set → 1, clear → 0, toggle → ~q_shadow.
    - If op is nop, or the target equals q_shadow for set/clear, consume the request and stay in IDLE with no pulse.
    - Otherwise go to PULSE. Load cnt = (req_len!=0 ? req_len : PULSE_W). From the next cycle drive S=1 if target=1, else R=1.
  - PULSE: hold S or R for exactly cnt cycles; decrement each cycle.
    - On the last pulse cycle, update q_shadow to the target at the same edge.
    - Then go to GAP if GAP_W>0, else go to IDLE.
  - GAP: S=R=0 for exactly GAP_W cycles, then go to IDLE.
- Latency: a request accepted at edge k produces S or R high in the cycle after edge k. The minimum accept-to-accept spacing is 1 + len + GAP_W cycles.
- Invariant: S&R is never 1 in any cycle, including reset and abort cycles.
- Feedback check:
  - Perform it in the first cycle after the final pulse cycle, regardless of the next state. The flip-flop updates one edge after the driver asserts S/R, so q_fb must already hold the new value in that cycle.
  - If q_fb != q_shadow, set err_mismatch at the following edge.
  - err_mismatch stays set until err_clr or rst. If err_clr and a new mismatch occur together, the set wins.
- The driver only samples req_op and req_len on a transfer. Changes while req_ready=0 are ignored.
- busy = (state != IDLE).

Test Plan:
- Reset, then set with req_len=0, PULSE_W=1, GAP_W=1 → S=1 for exactly 1 cycle starting 1 cycle after accept. q_shadow=1 at the end of the pulse. req_ready=0 for 2 cycles. q_fb=1 gives err_mismatch=0.
- Set with req_len=3, then clear → S high 3 cycles, 1 gap cycle, then R high for PULSE_W cycles. S and R never overlap. q_shadow goes 0→1→0.
- Redundant set while q_shadow=1, and nop → both consumed in one cycle each. S=R=0, busy stays 0.
- Two toggles back-to-back with req_valid held high → R pulse then S pulse, separated by GAP_W idle cycles. q_shadow ends at its starting value.
- Tie q_fb=0, then issue set → err_mismatch rises 2 cycles after the pulse ends and stays 1. Pulse err_clr → flag clears.
- Assert rst during the second cycle of a 4-cycle S pulse → S=0 the next cycle, q_shadow=0, req_ready=1 once rst drops.
- Random op/len stream → assert S&R==0 every cycle, and q_shadow equals a reference model of the flip-flop.
